complex_accumulate: RTL and testbench



---
 rtl/complex_pkg.sv | 18 +
 rtl/adder_subtractor.sv | 102 ++++++++++
 rtl/complex_add.sv | 37 +++
 rtl/complex_accumulate.sv | 100 ++++++++++
 tb/tb_complex_accumulate.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/complex_pkg.sv
// Shared types and field constants for the complex accumulate datapath.
// Complex words are packed {real, imag}, each an IEEE-754 single.
package complex_pkg;

    typedef enum logic [1:0] {
        ACCEPT,
        WAIT,
        HOLD
    } state_e;

    localparam int unsigned RE_MSB = 63;
    localparam int unsigned RE_LSB = 32;
    localparam int unsigned IM_MSB = 31;
    localparam int unsigned IM_LSB = 0;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/adder_subtractor.sv
// Pipelined IEEE-754 single-precision adder/subtractor (op_i=1 subtracts b_i).
// Round-to-nearest-even, gradual underflow, quiet NaN 7FC00000 on invalid.
module adder_subtractor #(
    parameter int unsigned LATENCY = 8
) (
    input  logic        clk_i,
    input  logic        ce_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        op_i,
    output logic [31:0] result_o
);

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  exe, eye, d, ef;
        logic [8:0]  er;
        logic [23:0] mx, my;
        logic [26:0] xr, yr, r, mask;
        logic [27:0] s;
        logic [30:0] packed_v;
        logic        a_nan, b_nan, a_inf, b_inf, sticky, rnd, sr, zero;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        x = (a[30:0] >= b[30:0]) ? a : b;
        y = (a[30:0] >= b[30:0]) ? b : a;
        exe = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        eye = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx  = {x[30:23] != 8'd0, x[22:0]};
        my  = {y[30:23] != 8'd0, y[22:0]};
        d   = exe - eye;
        xr  = {mx, 3'b000};
        yr  = {my, 3'b000};
        mask = '0;
        if (d > 8'd26) begin
            sticky = |my;
            yr     = '0;
        end else begin
            mask   = (27'd1 << d) - 27'd1;
            sticky = |(yr & mask);
            yr     = yr >> d;
        end
        yr[0] = yr[0] | sticky;
        er    = {1'b0, exe};
        sr    = x[31];
        s     = '0;
        zero  = 1'b0;
        if (x[31] == y[31]) begin
            s = {1'b0, xr} + {1'b0, yr};
            if (s[27]) begin
                r    = s[27:1];
                r[0] = r[0] | s[0];
                er   = er + 9'd1;
            end else begin
                r = s[26:0];
            end
        end else begin
            r    = xr - yr;
            zero = (r == 27'd0);
        end
        // Normalise left, stopping at the denormal exponent floor.
        for (int unsigned i = 0; i < 26; i++) begin
            if (!r[26] && er > 9'd1) begin
                r  = r << 1;
                er = er - 9'd1;
            end
        end
        ef       = r[26] ? er[7:0] : 8'd0;
        rnd      = r[2] & (r[1] | r[0] | r[3]);
        packed_v = {ef, r[25:3]} + {30'd0, rnd};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            res = 32'h7FC0_0000;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (zero) begin
            res = 32'h0000_0000;
        end else if (er >= 9'd255) begin
            res = {sr, 8'hFF, 23'd0};
        end else begin
            res = {sr, packed_v};
        end
        return res;
    endfunction

    logic [31:0] pipe_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            pipe_q[0] <= fp_add(a_i, {b_i[31] ^ op_i, b_i[30:0]});
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign result_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/complex_add.sv
// Packed complex adder: independent real and imaginary float adders
// sharing clock and enable, same latency on both halves.
module complex_add
    import complex_pkg::*;
#(
    parameter int unsigned LATENCY = 8
) (
    input  logic        clk_i,
    input  logic        ce_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o
);

    adder_subtractor #(
        .LATENCY(LATENCY)
    ) u_re (
        .clk_i    (clk_i),
        .ce_i     (ce_i),
        .a_i      (a_i[RE_MSB:RE_LSB]),
        .b_i      (b_i[RE_MSB:RE_LSB]),
        .op_i     (1'b0),
        .result_o (sum_o[RE_MSB:RE_LSB])
    );

    adder_subtractor #(
        .LATENCY(LATENCY)
    ) u_im (
        .clk_i    (clk_i),
        .ce_i     (ce_i),
        .a_i      (a_i[IM_MSB:IM_LSB]),
        .b_i      (b_i[IM_MSB:IM_LSB]),
        .op_i     (1'b0),
        .result_o (sum_o[IM_MSB:IM_LSB])
    );

endmodule

// File: rtl/complex_accumulate.sv
// Sums VEC_LEN packed complex products into one complex dot-product result,
// one element per adder pass, with valid/ready on both sides.
module complex_accumulate
    import complex_pkg::*;
#(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned ADD_LAT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    state_e             state_q, state_d;
    logic [63:0]        acc_q, acc_d;
    logic [63:0]        op_q, op_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   elem_q, elem_d;
    logic [63:0]        add_sum;
    logic [CNT_W-1:0]   elem_inc;

    // Adder inputs stay constant through WAIT, so its pipeline needs no valid tracking.
    complex_add #(
        .LATENCY(ADD_LAT)
    ) u_add (
        .clk_i (clk),
        .ce_i  (ce),
        .a_i   (acc_q),
        .b_i   (op_q),
        .sum_o (add_sum)
    );

    assign elem_inc = elem_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            acc_q   <= '0;
            op_q    <= '0;
            lat_q   <= '0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            lat_q   <= lat_d;
            elem_q  <= elem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        lat_d   = lat_q;
        elem_d  = elem_q;
        if (ce) begin
            unique case (state_q)
                ACCEPT: begin
                    if (in_valid) begin
                        op_d    = in_data;
                        lat_d   = CNT_W'(ADD_LAT);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        acc_d   = add_sum;
                        elem_d  = elem_inc;
                        state_d = (elem_inc == CNT_W'(VEC_LEN)) ? HOLD : ACCEPT;
                    end else begin
                        lat_d = lat_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc_d   = {FP_ZERO, FP_ZERO};
                        elem_d  = '0;
                        state_d = ACCEPT;
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_comb begin
        in_ready  = ce && (state_q == ACCEPT);
        out_valid = ce && (state_q == HOLD);
        out_data  = acc_q;
    end

endmodule

// File: tb/tb_complex_accumulate.sv
// Directed bench for complex_accumulate: driver pushes expected results into
// a scoreboard, a monitor pops and compares on each output transfer.
module tb_complex_accumulate;

    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned ADD_LAT = 8;
    localparam int unsigned GAP     = 10;   // accept-to-accept spacing with in_valid held high

    logic        clk = 1'b0;
    logic        rst_n, ce, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;

    typedef struct {
        logic [63:0] data;
        int unsigned span;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned first_acc = 0;
    int unsigned last_acc  = 0;

    complex_accumulate #(
        .VEC_LEN(VEC_LEN),
        .ADD_LAT(ADD_LAT),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    initial begin : monitor
        logic seen_rise;
        seen_rise = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    if (!seen_rise) begin
                        check("latency_last", 64'(cyc - last_acc), 64'(ADD_LAT + 2));
                        check("span", 64'(cyc - first_acc), 64'(sb[0].span));
                        seen_rise = 1'b1;
                    end
                    check("hold_in_ready", 64'(in_ready), 64'd0);
                    if (out_ready) begin
                        check("out_data", out_data, sb[0].data);
                        void'(sb.pop_front());
                        seen_rise = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_elem(input logic [63:0] d, output int unsigned acc_cyc);
        int unsigned waited;
        waited   = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3,
                           input logic [63:0] want, input int unsigned span,
                           input int unsigned ce_elem, input int unsigned stall);
        logic [63:0] d [4];
        int unsigned a, prev, waited;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        prev = 0;
        if (stall != 0) out_ready = 1'b0;
        sb.push_back('{data: want, span: span});
        for (int unsigned i = 0; i < 4; i++) begin
            send_elem(d[i], a);
            if (i == 0) first_acc = a;
            else check("accept_gap", 64'(a - prev), 64'((i == ce_elem) ? GAP + 3 : GAP));
            prev     = a;
            last_acc = a;
            if (i + 1 == ce_elem) begin
                repeat (3) @(posedge clk);
                #1 ce = 1'b0;
                for (int unsigned k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("ce_low_in_ready", 64'(in_ready), 64'd0);
                    check("ce_low_out_valid", 64'(out_valid), 64'd0);
                    @(posedge clk);
                    #1;
                end
                ce = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (stall != 0) begin
            waited = 0;
            @(negedge clk);
            while (!out_valid && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            for (int unsigned k = 0; k < stall; k++) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, want);
                if (k + 1 < stall) @(negedge clk);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
    endtask

    task automatic wait_drain();
        int unsigned waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int unsigned a;
        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1+1j, 2, 3j, 1-1j -> 4+3j
        run_vec(64'h3F800000_3F800000, 64'h40000000_00000000, 64'h00000000_40400000,
                64'h3F800000_BF800000, 64'h40800000_40400000, 40, 0, 0);
        wait_drain();

        // output stalled 5 cycles, then a fresh vector with no carry-over
        run_vec(64'h3F800000_3F800000, 64'h40000000_00000000, 64'h00000000_40400000,
                64'h3F800000_BF800000, 64'h40800000_40400000, 40, 0, 5);
        wait_drain();
        run_vec(64'h3F800000_3F800000, 64'h3F800000_3F800000, 64'h3F800000_3F800000,
                64'h3F800000_3F800000, 64'h40800000_40800000, 40, 0, 0);
        wait_drain();

        // ce low 3 cycles during WAIT of element 2 -> same sum, 3 cycles later
        run_vec(64'h3F800000_3F800000, 64'h40000000_00000000, 64'h00000000_40400000,
                64'h3F800000_BF800000, 64'h40800000_40400000, 43, 2, 0);
        wait_drain();

        // reset during WAIT of element 3 discards the partial sum
        send_elem(64'h40000000_40000000, a);
        send_elem(64'h40000000_40000000, a);
        send_elem(64'h40000000_40000000, a);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_acc", out_data, 64'h0);
        repeat (20) @(negedge clk);
        check("post_rst_idle", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        run_vec(64'h3F000000_BF000000, 64'h3F000000_BF000000, 64'h3F000000_BF000000,
                64'h3F000000_BF000000, 64'h40000000_C0000000, 40, 0, 0);
        wait_drain();

        // cancellation: 1+1j, -1-1j, 10, 10j -> 10+10j
        run_vec(64'h3F800000_3F800000, 64'hBF800000_BF800000, 64'h41200000_00000000,
                64'h00000000_41200000, 64'h41200000_41200000, 40, 0, 0);
        wait_drain();

        // negative zeros sum to +0.0
        run_vec(64'h80000000_80000000, 64'h80000000_80000000, 64'h80000000_80000000,
                64'h80000000_80000000, 64'h00000000_00000000, 40, 0, 0);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
